// File: rtl/i_buf_pkg.sv
// Shared types and constant helpers for the line-buffer writer and its pixel packer.
package i_buf_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StActive,
    StFlush,
    StDone,
    StDrop
  } buf_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  function automatic int unsigned pixels_per_word(input int unsigned bus_w,
                                                  input int unsigned pix_w);
    return bus_w / pix_w;
  endfunction

  // Never zero, so single-entry indices still get a legal 1-bit vector.
  function automatic int unsigned bank_idx_width(input int unsigned num_banks);
    return (num_banks < 2) ? 1 : clog2(num_banks);
  endfunction

endpackage

// File: rtl/i_buf_packer.sv
// Packs pixels into bus words, first pixel in the top lane; flush emits a zero-padded partial word.
module i_buf_packer
  import i_buf_pkg::*;
#(
  parameter int unsigned PixelWidth = 8,
  parameter int unsigned BusWidth   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  pix_valid_i,
  input  logic [PixelWidth-1:0] pixel_i,
  input  logic                  flush_i,
  output logic [BusWidth-1:0]   word_o,
  output logic                  word_valid_o,
  output logic                  partial_o
);

  localparam int unsigned Ppw   = pixels_per_word(BusWidth, PixelWidth);
  localparam int unsigned LaneW = (Ppw < 2) ? 1 : clog2(Ppw);

  logic [LaneW-1:0]    lane_q, lane_d;
  logic [BusWidth-1:0] shift_q, shift_d, acc;

  always_comb begin
    acc          = (shift_q << PixelWidth) | BusWidth'(pixel_i);
    lane_d       = lane_q;
    shift_d      = shift_q;
    word_o       = '0;
    word_valid_o = 1'b0;
    if (pix_valid_i) begin
      if (lane_q == LaneW'(Ppw - 1)) begin
        word_o       = acc;
        word_valid_o = 1'b1;
        lane_d       = '0;
        shift_d      = '0;
      end else begin
        lane_d  = lane_q + 1'b1;
        shift_d = acc;
      end
    end else if (flush_i && (lane_q != '0)) begin
      // Slide the held pixels up so the unused low lanes read as zero.
      word_o       = shift_q << (PixelWidth * (Ppw - 32'(lane_q)));
      word_valid_o = 1'b1;
      lane_d       = '0;
      shift_d      = '0;
    end
  end

  assign partial_o = (lane_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/i_buf_writer.sv
// Captures video lines into ring-ordered BRAM banks, raising line/frame pulses and sticky overflow.
module i_buf_writer
  import i_buf_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH   = 8,
  parameter int unsigned BUS_WIDTH     = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned LINE_WORDS    = 512,
  parameter int unsigned NUM_BANKS     = 2
) (
  input  logic                                    pclk,
  input  logic                                    reset_n,
  input  logic                                    vsync,
  input  logic                                    vde,
  input  logic [PIXEL_WIDTH-1:0]                  i_data,
  input  logic                                    line_ack,
  output logic                                    we,
  output logic [ADDRESS_WIDTH-1:0]                addr,
  output logic [BUS_WIDTH-1:0]                    o_data,
  output logic                                    line_valid,
  output logic [bank_idx_width(NUM_BANKS)-1:0]    line_bank,
  output logic                                    frame_valid,
  output logic                                    overflow
);

  localparam int unsigned BankW = bank_idx_width(NUM_BANKS);
  localparam int unsigned IdxW  = clog2(LINE_WORDS + 1);
  localparam int unsigned CntW  = clog2(NUM_BANKS + 1);

  buf_state_e               state_q;
  logic [BankW-1:0]         wr_ptr_q, rd_ptr_q, line_bank_q;
  logic [CntW-1:0]          full_count_q;
  logic [IdxW-1:0]          word_idx_q;
  logic                     we_q, line_valid_q, frame_valid_q, overflow_q, vsync_q;
  logic [ADDRESS_WIDTH-1:0] addr_q, wr_addr;
  logic [BUS_WIDTH-1:0]     o_data_q, pk_word;
  logic                     pk_valid, pk_partial, pix_valid, pk_flush;
  logic                     can_start, has_room, ack_ok;

  always_comb begin
    can_start = full_count_q < CntW'(NUM_BANKS);
    has_room  = word_idx_q < IdxW'(LINE_WORDS);
    pix_valid = vde && (((state_q == StIdle) && can_start) ||
                        ((state_q == StActive) && has_room));
    pk_flush  = (state_q == StActive) && !vde && pk_partial;
    // An ack landing with the bank-complete update still counts even from zero.
    ack_ok    = line_ack && ((full_count_q != '0) || (state_q == StFlush));
    wr_addr   = ADDRESS_WIDTH'(wr_ptr_q) * ADDRESS_WIDTH'(LINE_WORDS) +
                ADDRESS_WIDTH'(word_idx_q);
  end

  i_buf_packer #(
    .PixelWidth(PIXEL_WIDTH),
    .BusWidth  (BUS_WIDTH)
  ) u_packer (
    .clk_i       (pclk),
    .rst_ni      (reset_n),
    .pix_valid_i (pix_valid),
    .pixel_i     (i_data),
    .flush_i     (pk_flush),
    .word_o      (pk_word),
    .word_valid_o(pk_valid),
    .partial_o   (pk_partial)
  );

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      line_bank_q   <= '0;
      full_count_q  <= '0;
      word_idx_q    <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      o_data_q      <= '0;
      line_valid_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      vsync_q       <= 1'b0;
    end else begin
      we_q <= pk_valid;
      if (pk_valid) begin
        addr_q   <= wr_addr;
        o_data_q <= pk_word;
      end
      line_valid_q  <= 1'b0;
      vsync_q       <= vsync;
      frame_valid_q <= vsync && !vsync_q;
      full_count_q  <= full_count_q + CntW'(state_q == StFlush) - CntW'(ack_ok);
      rd_ptr_q      <= rd_ptr_q + BankW'(ack_ok);

      unique case (state_q)
        StIdle: begin
          word_idx_q <= IdxW'(pk_valid);
          if (vde) begin
            if (can_start) begin
              state_q <= StActive;
            end else begin
              state_q    <= StDrop;
              overflow_q <= 1'b1;
            end
          end
        end
        StActive: begin
          if (pk_valid) word_idx_q <= word_idx_q + 1'b1;
          if (vde && !has_room) overflow_q <= 1'b1;
          if (!vde) state_q <= StFlush;
        end
        StFlush: begin
          line_valid_q <= 1'b1;
          line_bank_q  <= wr_ptr_q;
          wr_ptr_q     <= wr_ptr_q + 1'b1;
          if (vde) begin
            state_q    <= StDrop;
            overflow_q <= 1'b1;
          end else begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (vde) begin
            state_q    <= StDrop;
            overflow_q <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        StDrop: begin
          if (!vde) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign we          = we_q;
  assign addr        = addr_q;
  assign o_data      = o_data_q;
  assign line_valid  = line_valid_q;
  assign line_bank   = line_bank_q;
  assign frame_valid = frame_valid_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_i_buf_writer.sv
// Self-checking bench for i_buf_writer with a 4-word, 2-bank configuration.
module tb_i_buf_writer;

  localparam int LW  = 4;
  localparam int NB  = 2;
  localparam int PPW = 4;

  logic        pclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vsync = 1'b0;
  logic        vde = 1'b0;
  logic        line_ack = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        we, line_valid, frame_valid, overflow;
  logic [31:0] addr, o_data;
  logic [0:0]  line_bank;

  i_buf_writer #(
    .PIXEL_WIDTH  (8),
    .BUS_WIDTH    (32),
    .ADDRESS_WIDTH(32),
    .LINE_WORDS   (LW),
    .NUM_BANKS    (NB)
  ) dut (
    .pclk       (pclk),
    .reset_n    (reset_n),
    .vsync      (vsync),
    .vde        (vde),
    .i_data     (i_data),
    .line_ack   (line_ack),
    .we         (we),
    .addr       (addr),
    .o_data     (o_data),
    .line_valid (line_valid),
    .line_bank  (line_bank),
    .frame_valid(frame_valid),
    .overflow   (overflow)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t        wr_q[$];
  int         lv_c[$];
  logic [0:0] lv_b[$];
  int         fv_c[$];

  always @(negedge pclk) begin
    if (we) wr_q.push_back('{addr, o_data, cyc});
    if (line_valid) begin
      lv_c.push_back(cyc);
      lv_b.push_back(line_bank);
    end
    if (frame_valid) fv_c.push_back(cyc);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: bank occupancy, write pointer and sticky error.
  int          m_full, m_wr;
  bit          m_ovf;
  logic [7:0]  px_q[$];
  int          d_cyc[$];
  int          t_end;
  logic [31:0] exp_a[$], exp_d[$];
  bit          exp_lv;
  logic [0:0]  exp_bank;

  function automatic logic [31:0] pack_word(input int w);
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < PPW; j++) begin
      if (w * PPW + j < px_q.size()) v[8*(PPW-1-j) +: 8] = px_q[w*PPW+j];
    end
    return v;
  endfunction

  task automatic model_line();
    int nw;
    exp_a.delete();
    exp_d.delete();
    exp_lv   = 1'b0;
    exp_bank = '0;
    if (m_full == NB) begin
      m_ovf = 1'b1;
    end else begin
      nw = (px_q.size() + PPW - 1) / PPW;
      if (nw > LW) begin
        nw    = LW;
        m_ovf = 1'b1;
      end
      for (int w = 0; w < nw; w++) begin
        exp_a.push_back(32'(m_wr * LW + w));
        exp_d.push_back(pack_word(w));
      end
      exp_lv   = 1'b1;
      exp_bank = 1'(m_wr);
      m_wr     = (m_wr + 1) % NB;
      m_full++;
    end
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    vde      = 1'b0;
    vsync    = 1'b0;
    line_ack = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    reset_n = 1'b1;
    @(posedge pclk);
    #1;
    m_full = 0;
    m_wr   = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic do_ack();
    line_ack = 1'b1;
    @(posedge pclk);
    #1;
    line_ack = 1'b0;
    if (m_full > 0) m_full--;
  endtask

  // ack_off >= 0 pulses line_ack that many cycles after the first vde=0 cycle.
  task automatic drive_line(input int ack_off);
    wr_q.delete();
    lv_c.delete();
    lv_b.delete();
    d_cyc.delete();
    foreach (px_q[i]) begin
      vde    = 1'b1;
      i_data = px_q[i];
      d_cyc.push_back(cyc);
      @(posedge pclk);
      #1;
    end
    vde    = 1'b0;
    i_data = 8'h00;
    t_end  = cyc;
    for (int k = 0; k < 6; k++) begin
      line_ack = (k == ack_off);
      @(posedge pclk);
      #1;
    end
    line_ack = 1'b0;
  endtask

  task automatic fill_px(input int n, input logic [7:0] first, input bit rnd);
    px_q.delete();
    for (int i = 0; i < n; i++) px_q.push_back(rnd ? 8'($urandom) : 8'(first + 8'(i)));
  endtask

  task automatic check_line(input string tag);
    chk({tag, "_nwr"}, wr_q.size(), exp_a.size());
    for (int i = 0; i < wr_q.size() && i < exp_a.size(); i++) begin
      chk({tag, "_addr"}, wr_q[i].a, exp_a[i]);
      chk({tag, "_data"}, wr_q[i].d, exp_d[i]);
    end
    chk({tag, "_nlv"}, lv_c.size(), exp_lv);
    if (exp_lv && lv_b.size() > 0) chk({tag, "_bank"}, lv_b[0], exp_bank);
    chk({tag, "_ovf"}, overflow, m_ovf);
  endtask

  typedef struct {
    bit         rst;
    bit         ack;
    int         npix;
    logic [7:0] first;
    int         words;
    logic [0:0] bank;
    bit         lv;
    bit         ovf;
  } vec_t;

  vec_t tab[7];

  initial begin
    tab[0] = '{1'b1, 1'b0, 8,  8'h01, 2, 1'b0, 1'b1, 1'b0};
    tab[1] = '{1'b0, 1'b0, 6,  8'hA0, 2, 1'b1, 1'b1, 1'b0};
    tab[2] = '{1'b0, 1'b0, 5,  8'h30, 0, 1'b0, 1'b0, 1'b1};
    tab[3] = '{1'b0, 1'b1, 4,  8'h40, 1, 1'b0, 1'b1, 1'b1};
    tab[4] = '{1'b1, 1'b0, 20, 8'h50, 4, 1'b0, 1'b1, 1'b1};
    tab[5] = '{1'b0, 1'b0, 3,  8'h70, 1, 1'b1, 1'b1, 1'b1};
    tab[6] = '{1'b0, 1'b1, 1,  8'h80, 1, 1'b0, 1'b1, 1'b1};

    do_reset();
    chk("rst_we", we, 1'b0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_data", o_data, 32'h0);
    chk("rst_flags", {line_valid, line_bank, frame_valid, overflow}, 4'h0);

    // Frame pulse: one cycle after vsync is first sampled high.
    fv_c.delete();
    begin
      int c0;
      c0    = cyc;
      vsync = 1'b1;
      repeat (3) @(posedge pclk);
      #1;
      vsync = 1'b0;
      repeat (2) @(posedge pclk);
      #1;
      chk("fv_count", fv_c.size(), 1);
      if (fv_c.size() > 0) chk("fv_cycle", fv_c[0], c0 + 1);
    end

    // Latency of full words, flush write and line_valid.
    fill_px(8, 8'h01, 1'b0);
    model_line();
    drive_line(-1);
    check_line("A1");
    if (wr_q.size() >= 2) begin
      chk("A1_w0", {wr_q[0].a, wr_q[0].d}, {32'h0, 32'h01020304});
      chk("A1_w1", {wr_q[1].a, wr_q[1].d}, {32'h1, 32'h05060708});
      chk("A1_w0_cyc", wr_q[0].c, d_cyc[3] + 1);
      chk("A1_w1_cyc", wr_q[1].c, d_cyc[7] + 1);
    end
    if (lv_c.size() > 0) chk("A1_lv_cyc", lv_c[0], t_end + 2);

    fill_px(6, 8'hA0, 1'b0);
    model_line();
    drive_line(-1);
    check_line("A2");
    if (wr_q.size() >= 2) begin
      chk("A2_flush", {wr_q[1].a, wr_q[1].d}, {32'h5, 32'hA4A50000});
      chk("A2_flush_cyc", wr_q[1].c, t_end + 1);
    end
    if (lv_c.size() > 0) chk("A2_lv_cyc", lv_c[0], t_end + 2);

    // Table-driven lines.
    for (int r = 0; r < 7; r++) begin
      if (tab[r].rst) do_reset();
      if (tab[r].ack) do_ack();
      fill_px(tab[r].npix, tab[r].first, 1'b0);
      model_line();
      drive_line(-1);
      check_line($sformatf("T%0d", r));
      chk($sformatf("T%0d_tab_nwr", r), wr_q.size(), tab[r].words);
      chk($sformatf("T%0d_tab_nlv", r), lv_c.size(), tab[r].lv);
      if (tab[r].lv && lv_b.size() > 0) chk($sformatf("T%0d_tab_bank", r), lv_b[0], tab[r].bank);
      chk($sformatf("T%0d_tab_ovf", r), overflow, tab[r].ovf);
    end

    // line_ack coincident with DONE leaves the occupancy unchanged.
    do_reset();
    fill_px(4, 8'h10, 1'b0);
    model_line();
    drive_line(-1);
    check_line("B1");
    fill_px(4, 8'h20, 1'b0);
    model_line();
    if (m_full > 0) m_full--;
    drive_line(2);
    check_line("B2");
    fill_px(4, 8'h30, 1'b0);
    model_line();
    drive_line(-1);
    check_line("B3");
    chk("B3_ovf_clear", overflow, 1'b0);
    fill_px(4, 8'h40, 1'b0);
    model_line();
    drive_line(-1);
    check_line("B4");
    chk("B4_ovf_set", overflow, 1'b1);

    // Asynchronous reset in the middle of an over-long line.
    do_reset();
    fill_px(20, 8'hC0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      vde    = 1'b1;
      i_data = px_q[i];
      @(posedge pclk);
      #1;
    end
    chk("C_ovf_pre", overflow, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("C_we", we, 1'b0);
    chk("C_addr", addr, 32'h0);
    chk("C_data", o_data, 32'h0);
    chk("C_flags", {line_valid, line_bank, frame_valid, overflow}, 4'h0);
    vde    = 1'b0;
    i_data = 8'h00;
    repeat (2) @(posedge pclk);
    #1;
    reset_n = 1'b1;
    @(posedge pclk);
    #1;
    m_full = 0;
    m_wr   = 0;
    m_ovf  = 1'b0;
    fill_px(4, 8'hD0, 1'b0);
    model_line();
    drive_line(-1);
    check_line("C_after");
    if (wr_q.size() > 0) chk("C_after_addr0", wr_q[0].a, 32'h0);

    // Randomised lines and acks against the model.
    do_reset();
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) do_ack();
      fill_px(int'($urandom_range(1, 18)), 8'h00, 1'b1);
      model_line();
      drive_line(-1);
      check_line($sformatf("R%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
